// File: rtl/xorwow_pkg.sv
// xorwow shared types and default seeds.
// Seeds are Marsaglia's reference values.
package xorwow_pkg;

    typedef logic [31:0] word_t;

    localparam word_t DEF_SEED_X = 32'd123456789;
    localparam word_t DEF_SEED_Y = 32'd362436069;
    localparam word_t DEF_SEED_Z = 32'd521288629;
    localparam word_t DEF_SEED_W = 32'd88675123;
    localparam word_t DEF_SEED_V = 32'd5783321;
    localparam word_t DEF_SEED_D = 32'd6615241;
    localparam word_t DEF_WEYL_INC = 32'd362437;

endpackage

// File: rtl/xorwow_step.sv
// xorwow next-state logic, purely combinational.
// Produces the shifted state, new Weyl count and output sum.
module xorwow_step
    import xorwow_pkg::*;
#(
    parameter word_t WEYL_INC = DEF_WEYL_INC
) (
    input  word_t x,
    input  word_t y,
    input  word_t z,
    input  word_t w,
    input  word_t v,
    input  word_t d,
    output word_t nx,
    output word_t ny,
    output word_t nz,
    output word_t nw,
    output word_t nv,
    output word_t nd,
    output word_t sum
);

    word_t t;

    // xorshift mix, Weyl advance and output sum
    always_comb begin
        t   = x ^ (x >> 2);
        nx  = y;
        ny  = z;
        nz  = w;
        nw  = v;
        nv  = (v ^ (v << 4)) ^ (t ^ (t << 1));
        nd  = d + WEYL_INC;
        sum = nv + nd;
    end

endmodule

// File: rtl/xorwow.sv
// Free-running xorwow PRNG, one 32-bit word per clock.
// Sequence is deterministic from the seed parameters.
module xorwow
    import xorwow_pkg::*;
#(
    parameter word_t SEED_X   = DEF_SEED_X,
    parameter word_t SEED_Y   = DEF_SEED_Y,
    parameter word_t SEED_Z   = DEF_SEED_Z,
    parameter word_t SEED_W   = DEF_SEED_W,
    parameter word_t SEED_V   = DEF_SEED_V,
    parameter word_t SEED_D   = DEF_SEED_D,
    parameter word_t WEYL_INC = DEF_WEYL_INC
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] random
);

    word_t st_x, st_y, st_z, st_w, st_v, st_d;
    word_t nx, ny, nz, nw, nv, nd, sum;

    xorwow_step #(
        .WEYL_INC(WEYL_INC)
    ) u_step (
        .x  (st_x),
        .y  (st_y),
        .z  (st_z),
        .w  (st_w),
        .v  (st_v),
        .d  (st_d),
        .nx (nx),
        .ny (ny),
        .nz (nz),
        .nw (nw),
        .nv (nv),
        .nd (nd),
        .sum(sum)
    );

    // load seeds on reset, otherwise advance every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            st_x   <= SEED_X;
            st_y   <= SEED_Y;
            st_z   <= SEED_Z;
            st_w   <= SEED_W;
            st_v   <= SEED_V;
            st_d   <= SEED_D;
            random <= '0;
        end else begin
            st_x   <= nx;
            st_y   <= ny;
            st_z   <= nz;
            st_w   <= nw;
            st_v   <= nv;
            st_d   <= nd;
            random <= sum;
        end
    end

endmodule

// File: tb/tb_xorwow.sv
// Directed checks of xorwow against hand values and a reference model.
// Three instances: default seeds, wrapping Weyl seed, custom seeds.
module tb_xorwow;
    import xorwow_pkg::*;

    typedef struct packed {
        word_t x, y, z, w, v, d;
    } mst_t;

    localparam word_t FIRST  = 32'h0EB70507;
    localparam word_t WRAP_D = 32'hFFFFFFF0;
    localparam word_t A_X = 32'hDEADBEEF;
    localparam word_t A_Y = 32'h01234567;
    localparam word_t A_Z = 32'h89ABCDEF;
    localparam word_t A_W = 32'hCAFEF00D;
    localparam word_t A_V = 32'h13579BDF;
    localparam word_t A_D = 32'h00000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] r_def, r_wrap, r_alt;

    int total = 0;
    int bad = 0;

    mst_t m_def, m_wrap, m_alt;
    word_t e_def, e_wrap, e_alt;

    always #5 clk = ~clk;

    xorwow u_def (
        .clk   (clk),
        .rst   (rst),
        .random(r_def)
    );

    xorwow #(
        .SEED_D(WRAP_D)
    ) u_wrap (
        .clk   (clk),
        .rst   (rst),
        .random(r_wrap)
    );

    xorwow #(
        .SEED_X(A_X), .SEED_Y(A_Y), .SEED_Z(A_Z),
        .SEED_W(A_W), .SEED_V(A_V), .SEED_D(A_D)
    ) u_alt (
        .clk   (clk),
        .rst   (rst),
        .random(r_alt)
    );

    task automatic chk(input string tag, input word_t got, input word_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Textbook xorwow, written from the published algorithm
    function automatic mst_t mstep(input mst_t s, output word_t out);
        mst_t n;
        word_t t;
        t   = s.x ^ (s.x >> 2);
        n.x = s.y;
        n.y = s.z;
        n.z = s.w;
        n.w = s.v;
        n.v = (s.v ^ (s.v << 4)) ^ (t ^ (t << 1));
        n.d = s.d + 32'd362437;
        out = n.v + n.d;
        return n;
    endfunction

    function automatic mst_t mseed(input word_t x, y, z, w, v, d);
        mst_t s;
        s.x = x; s.y = y; s.z = z; s.w = w; s.v = v; s.d = d;
        return s;
    endfunction

    task automatic mreset();
        m_def  = mseed(32'd123456789, 32'd362436069, 32'd521288629,
                       32'd88675123, 32'd5783321, 32'd6615241);
        m_wrap = m_def;
        m_wrap.d = WRAP_D;
        m_alt  = mseed(A_X, A_Y, A_Z, A_W, A_V, A_D);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv_check(input string tag);
        m_def  = mstep(m_def, e_def);
        m_wrap = mstep(m_wrap, e_wrap);
        m_alt  = mstep(m_alt, e_alt);
        chk({tag, "_def"}, r_def, e_def);
        chk({tag, "_wrap"}, r_wrap, e_wrap);
        chk({tag, "_alt"}, r_alt, e_alt);
    endtask

    task automatic rst_check(input string tag);
        chk({tag, "_def"}, r_def, 32'h0);
        chk({tag, "_wrap"}, r_wrap, 32'h0);
        chk({tag, "_alt"}, r_alt, 32'h0);
        chk({tag, "_sx"}, u_def.st_x, 32'd123456789);
        chk({tag, "_sv"}, u_def.st_v, 32'd5783321);
        chk({tag, "_sd"}, u_def.st_d, 32'd6615241);
    endtask

    initial begin
        mreset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            rst_check("reset");
        end

        rst = 1'b0;
        tick();
        chk("first", r_def, FIRST);
        chk("first_x", u_def.st_x, 32'd362436069);
        chk("first_v", u_def.st_v, 32'h0E4C8C79);
        chk("first_d", u_def.st_d, 32'h006A788E);
        chk("wrap_d", u_wrap.st_d, 32'h000587B5);
        adv_check("first_model");

        for (int i = 1; i < 1000; i++) begin
            if (i == 500) begin
                rst = 1'b1;
                tick();
                rst_check("midrst");
                mreset();
                rst = 1'b0;
                tick();
                chk("midrst_first", r_def, FIRST);
                adv_check("midrst_model");
            end else begin
                tick();
                adv_check("run");
            end
        end

        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            rst_check("held");
        end
        mreset();
        rst = 1'b0;
        tick();
        chk("held_first", r_def, FIRST);
        adv_check("held_model");
        for (int i = 0; i < 20; i++) begin
            tick();
            adv_check("tail");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
